spi_slave: RTL
==============

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the word length in bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the synchroniser depth on SCLK, CS and MOSI (minimum 2).
REQ-003 SHALL have port clk  in  1  system clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port cpol  in  1  clock polarity; SCLK idle level.
REQ-006 SHALL have port cpha  in  1  clock phase; 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-007 SHALL have port SCLK  in  1  serial clock from master, asynchronous to clk.
REQ-008 SHALL have port CS  in  1  chip select, active-low, asynchronous to clk.
REQ-009 SHALL have port MOSI  in  1  serial data from master.
REQ-010 SHALL have port MISO  out  1  serial data to master, registered.
REQ-011 SHALL have port tx_data  in  WIDTH  next word to transmit.
REQ-012 SHALL have port tx_valid  in  1  tx_data valid.
REQ-013 SHALL have port tx_ready  out  1  tx buffer empty.
REQ-014 SHALL have port rx_data  out  WIDTH  last received word.
REQ-015 SHALL have port rx_valid  out  1  rx_data holds an unacknowledged word.
REQ-016 SHALL have port rx_ack  in  1  consumer takes rx_data.
REQ-017 SHALL have port busy  out  1  synchronised CS is low.
REQ-018 SHALL have port overrun  out  1  sticky: unacknowledged word overwritten.

Function
REQ-019 SHALL pass SCLK, CS and MOSI through SYNC_STAGES flops each.
REQ-020 SHALL detect SCLK edges by comparing the synchronised SCLK with its registered previous value, giving one-clk strobes.
REQ-021 SHALL latch cpol and cpha on the synchronised CS falling edge; changes while CS is low SHALL be ignored.
REQ-022 SHALL define the leading edge as SCLK leaving the latched cpol level and the trailing edge as SCLK returning to it.
REQ-023 SHALL use states IDLE (CS high), LOAD (one clk after CS fall) and XFER (CS low); LOAD->XFER is unconditional; any state -> IDLE on synchronised CS rise.
REQ-024 SHALL transfer MSB first, for both MOSI and MISO.
REQ-025 SHALL load the tx shift register at each word start (LOAD, or XFER at bit-count wrap) from the tx buffer if it is full, then empty the buffer; if the buffer is empty it SHALL load all zeros.
REQ-026 with cpha=0, SHALL present the MSB on MISO in LOAD, sample MOSI on leading edges and shift MISO on trailing edges.
REQ-027 with cpha=1, SHALL shift MISO on leading edges, with the first leading edge presenting the MSB, and sample MOSI on trailing edges.
REQ-028 SHALL count samples modulo WIDTH; on the WIDTH-th sample it SHALL write rx_data, set rx_valid and wrap the count, so multiple words per CS frame are supported.
REQ-029 SHALL update rx_data and rx_valid on the same clk edge the last bit is sampled, i.e. SYNC_STAGES+1 clk after the raw SCLK edge.
REQ-030 SHALL hold rx_valid until rx_ack is seen with rx_valid high.
REQ-031 on word completion and rx_ack in the same cycle, SHALL keep rx_valid=1 with the new data and leave overrun=0.
REQ-032 on word completion while rx_valid=1 without rx_ack, SHALL overwrite rx_data and set overrun until reset.
REQ-033 SHALL drive tx_ready = tx buffer empty, and SHALL accept tx_data when tx_valid and tx_ready are both high.
REQ-034 on CS rise mid-word, SHALL discard the partial rx and tx shift contents, clear the count, assert no rx_valid and leave the tx buffer unchanged.
REQ-035 SHALL drive MISO=0 in IDLE.
REQ-036 SHALL require an SCLK half-period of at least SYNC_STAGES+2 clk; behaviour for faster SCLK is undefined.

Reset
REQ-037 rst=1 SHALL immediately force IDLE, MISO=0, tx_ready=1, tx buffer empty, rx_data=0, rx_valid=0, busy=0, overrun=0, count=0, CS sync flops=1, SCLK sync flops=0 and latched mode=00.
REQ-038 SHALL treat reset during XFER as an aborted frame with no rx_valid; after release, the next CS fall starts a new frame normally.

Verification
REQ-039 Mode 0: load tx 0xA5, master sends 0x3C -> rx_data=0x3C, rx_valid=1, MISO bits 1,0,1,0,0,1,0,1.
REQ-040 Mode 3: load tx 0xC3, master sends 0x5A -> rx_data=0x5A, MISO bits 1,1,0,0,0,0,1,1, with bits sampled on trailing edges.
REQ-041 One frame, words 0x11 then 0x22, no rx_ack -> rx_data=0x22, rx_valid=1, overrun=1; an rx_ack on the 0x22 completion cycle instead -> overrun=0.
REQ-042 CS rises after 5 bits, then a full frame 0x81 -> no rx_valid from the partial word, then rx_data=0x81.
REQ-043 No tx_valid; cpol toggled mid-frame -> MISO all 0, bits still sampled per the latched mode, rx_data correct.
REQ-044 rst pulsed mid-frame -> all outputs at reset values in the same cycle; the following frame 0xF0 -> rx_data=0xF0.

Source files
------------

// File: rtl/spi_slave.sv
// SPI slave with run-time CPOL/CPHA, oversampled from the system clock, with a
// one-word tx buffer and an rx holding register with overrun detection.
module spi_slave #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpol,
    input  logic             cpha,
    input  logic             SCLK,
    input  logic             CS,
    input  logic             MOSI,
    output logic             MISO,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ack,
    output logic             busy,
    output logic             overrun
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, LOAD, XFER} state_t;

    state_t state, next_state;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_s, cs_s, mosi_s, sclk_prev;
    logic                   mode_cpol, mode_cpha;
    logic [CNT_W-1:0]       count;
    logic [WIDTH-2:0]       rx_shift;
    logic [WIDTH-1:0]       rx_next;
    logic [WIDTH-1:0]       tx_shift, tx_buf, load_word;
    logic                   tx_full;
    logic                   rise, fall, leading, trailing;
    logic                   active, sample, present, last, done;

    // Input synchronisers; CS idles high, SCLK idles low out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sclk_prev <= sclk_s;
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign busy   = ~cs_s;

    assign rise      = sclk_s & ~sclk_prev;
    assign fall      = ~sclk_s & sclk_prev;
    assign leading   = mode_cpol ? fall : rise;
    assign trailing  = mode_cpol ? rise : fall;
    assign active    = (state == XFER) && !cs_s;
    assign sample    = active && (mode_cpha ? trailing : leading);
    assign present   = active && (mode_cpha ? leading : trailing);
    assign last      = (count == CNT_W'(WIDTH - 1));
    assign done      = sample && last;
    assign load_word = tx_full ? tx_buf : '0;
    assign rx_next   = {rx_shift, mosi_s};
    assign tx_ready  = ~tx_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!cs_s) next_state = LOAD;
            LOAD:    next_state = cs_s ? IDLE : XFER;
            XFER:    if (cs_s) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Mode is frozen for the whole frame at the synchronised CS fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_cpol <= 1'b0;
            mode_cpha <= 1'b0;
        end else if (state == IDLE && !cs_s) begin
            mode_cpol <= cpol;
            mode_cpha <= cpha;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
            tx_full  <= 1'b0;
            MISO     <= 1'b0;
        end else begin
            if (state == IDLE)
                count <= '0;
            else if (sample)
                count <= last ? '0 : count + 1'b1;

            // A completing word wins over a same-cycle ack: the new word stays pending
            if (done) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
                if (rx_valid && !rx_ack)
                    overrun <= 1'b1;
            end else if (rx_valid && rx_ack) begin
                rx_valid <= 1'b0;
            end

            if ((state == LOAD || done) && tx_full)
                tx_full <= 1'b0;
            else if (tx_valid && !tx_full)
                tx_full <= 1'b1;

            if (state == IDLE)
                MISO <= 1'b0;
            else if (state == LOAD && !mode_cpha)
                MISO <= load_word[WIDTH-1];
            else if (present)
                MISO <= tx_shift[WIDTH-1];
        end
    end

    // tx_shift holds the bits not yet presented on MISO
    always_ff @(posedge clk) begin
        if (tx_valid && !tx_full)
            tx_buf <= tx_data;

        if (state == IDLE)
            rx_shift <= '0;
        else if (sample)
            rx_shift <= rx_next[WIDTH-2:0];

        if (state == IDLE)
            tx_shift <= '0;
        else if (state == LOAD)
            tx_shift <= mode_cpha ? load_word : (load_word << 1);
        else if (done)
            tx_shift <= load_word;
        else if (present)
            tx_shift <= tx_shift << 1;
    end

endmodule
